// File: rtl/ifetch_queue.sv
// Instruction fetch queue: owns the PC, issues word fetches, buffers responses in order for decode.
// Optional fetch-misalignment exception entries are enabled with `define IFETCH_MISALIGN_EXC_EN.
module ifetch_queue #(
  parameter int unsigned          XLEN         = 32,
  parameter int unsigned          FIFO_DEPTH   = 4,
  parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_adr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_v_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_misalign_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            mis_pend_q, mis_pend_d;
  logic [XLEN-1:0] mis_pc_q, mis_pc_d;

  logic [XLEN-1:0] instr_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_mem_q    [FIFO_DEPTH];

  logic            grant, pop, resp_keep, mis_push, push, redir_mis, credit_ok;
  logic [XLEN-1:0] push_instr, push_pc, redir_pc_aligned;

  assign redir_pc_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};
`ifdef IFETCH_MISALIGN_EXC_EN
  assign redir_mis = redirect_v_i & (redirect_pc_i[1:0] != 2'b00);
`else
  assign redir_mis = 1'b0;
`endif

  // Credit covers both buffered and in-flight words, so responses never need backpressure.
  assign credit_ok  = ({1'b0, count_q} + {1'b0, out_q}) < (CW + 1)'(FIFO_DEPTH);
  assign imem_adr_o = pc_q;
  assign valid_o    = (count_q != '0);
  assign instr_o    = valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign pc_o       = valid_o ? pc_mem_q[rd_ptr_q]    : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_v_i)           state_d = redir_mis ? HALT : FETCH;
    else if (state_q == BOOT)   state_d = FETCH;
  end

  always_comb begin
    imem_req_o = 1'b0;
    if (state_q == FETCH) imem_req_o = ~redirect_v_i & credit_ok;
  end

  always_comb begin
    grant      = imem_req_o & imem_gnt_i;
    pop        = valid_o & ready_i;
    resp_keep  = imem_rvalid_i & ~redirect_v_i & (drop_q == '0);
    // A pending misaligned entry only lands when no response can be kept (all are being dropped).
    mis_push   = mis_pend_q & ~redirect_v_i;
    push       = resp_keep | mis_push;
    push_instr = mis_push ? '0 : imem_rdata_i;
    push_pc    = mis_push ? mis_pc_q : resp_pc_q;

    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    out_d      = out_q + CW'(grant) - CW'(imem_rvalid_i);
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mis_pend_d = 1'b0;
    mis_pc_d   = mis_pc_q;

    if (redirect_v_i) begin
      pc_d       = redir_pc_aligned;
      resp_pc_d  = redir_pc_aligned;
      drop_d     = out_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      mis_pend_d = redir_mis;
      mis_pc_d   = redirect_pc_i;
    end else begin
      if (grant)                             pc_d      = pc_q + XLEN'(4);
      if (imem_rvalid_i && (drop_q != '0))   drop_d    = drop_q - 1'b1;
      if (resp_keep)                         resp_pc_d = resp_pc_q + XLEN'(4);
      if (push)                              wr_ptr_d  = wr_ptr_q + 1'b1;
      if (pop)                               rd_ptr_d  = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q       <= RESET_VECTOR;
      resp_pc_q  <= RESET_VECTOR;
      out_q      <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      mis_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      mis_pend_q <= mis_pend_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    mis_pc_q <= mis_pc_d;
    if (push) begin
      instr_mem_q[wr_ptr_q] <= push_instr;
      pc_mem_q[wr_ptr_q]    <= push_pc;
    end
  end

`ifdef IFETCH_MISALIGN_EXC_EN
  logic mis_mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (push) mis_mem_q[wr_ptr_q] <= mis_push;
  end

  assign instr_misalign_o = valid_o & mis_mem_q[rd_ptr_q];
`else
  assign instr_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed fetch/redirect scenarios with an in-order memory model.
`timescale 1ns/1ps
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_adr_o, imem_rdata_i;
  logic        redirect_v_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o, ready_i, instr_misalign_o;
  logic [31:0] instr_o, pc_o;

  logic gnt_en;
  int   mem_lat;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   first_pop = -1;
  int   last_pop = -1;

  typedef struct packed {logic [31:0] instr; logic [31:0] pc; logic mis;} out_t;
  typedef struct packed {logic [31:0] adr; int due;} pend_t;

  out_t        exp_out[$];
  logic [31:0] exp_adr[$];
  pend_t       pend[$];

  ifetch_queue #(.XLEN(32), .FIFO_DEPTH(4), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_o(imem_req_o), .imem_adr_o(imem_adr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_v_i(redirect_v_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o),
    .instr_misalign_o(instr_misalign_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory grants only while a request is up.
  assign imem_gnt_i = gnt_en & imem_req_o;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0F0F};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic exp_fetch(input logic [31:0] a);
    exp_adr.push_back(a);
    exp_out.push_back('{instr: mem_word(a), pc: a, mis: 1'b0});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // In-order memory: responds mem_lat cycles after each grant, one word per cycle.
  always begin
    @(negedge clk); #1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    if (reset_n !== 1'b1) begin
      pend.delete();
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(pend[0].adr);
        void'(pend.pop_front());
      end
      if (imem_req_o && imem_gnt_i) pend.push_back('{adr: imem_adr_o, due: cyc + mem_lat});
    end
  end

  // Monitor: compares every granted address and every consumed head against the scoreboard.
  always begin
    out_t e;
    @(negedge clk); #2;
    if (reset_n === 1'b1) begin
      if (imem_req_o && imem_gnt_i) begin
        if (exp_adr.size() == 0) begin
          n_checks++;
          $display("FAIL adr_unexpected: got grant at 0x%08h, expected no grant", imem_adr_o);
        end else begin
          check("adr", imem_adr_o, exp_adr.pop_front());
        end
      end
      if (valid_o && ready_i) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_out.size() == 0) begin
          n_checks++;
          $display("FAIL out_unexpected: got pc 0x%08h, expected no output", pc_o);
        end else begin
          e = exp_out.pop_front();
          check("out_pc", pc_o, e.pc);
          check("out_instr", instr_o, e.instr);
          check("out_mis", 32'(instr_misalign_o), 32'(e.mis));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ready_i = 1'b1; gnt_en = 1'b0; mem_lat = 1;
    redirect_v_i = 1'b0; redirect_pc_i = '0;

    // Reset state
    step(3); #2;
    check("rst_req", 32'(imem_req_o), 0);
    check("rst_adr", imem_adr_o, 32'h0);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_instr", instr_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_mis", 32'(instr_misalign_o), 0);

    // Boot then sustained streaming of 8 words
    @(negedge clk); reset_n = 1'b1;
    #2 check("boot_req", 32'(imem_req_o), 0);
    @(negedge clk); gnt_en = 1'b1;
    for (int i = 0; i < 8; i++) exp_fetch(32'(i * 4));
    #2 check("first_req", 32'(imem_req_o), 1);
    check("first_adr", imem_adr_o, 32'h0);
    step(8); gnt_en = 1'b0;
    step(6); #2;
    check("sustained_rate", 32'(last_pop - first_pop), 7);
    check("held_req", 32'(imem_req_o), 1);
    check("held_adr", imem_adr_o, 32'h20);
    step(3); #2;
    check("held_adr_later", imem_adr_o, 32'h20);

    // Backpressure: exactly FIFO_DEPTH grants then requests stop
    @(negedge clk); ready_i = 1'b0; gnt_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_fetch(32'h20 + 32'(i * 4));
    step(8); #2;
    check("bp_req_off", 32'(imem_req_o), 0);
    check("bp_valid", 32'(valid_o), 1);
    check("bp_head_pc", pc_o, 32'h20);
    @(negedge clk); gnt_en = 1'b0; ready_i = 1'b1;
    step(6); #2;
    check("bp_resume_req", 32'(imem_req_o), 1);
    check("bp_resume_adr", imem_adr_o, 32'h30);
    @(negedge clk); gnt_en = 1'b1; exp_fetch(32'h30); exp_fetch(32'h34);
    step(2); gnt_en = 1'b0;
    step(5);

    // Redirect with three slow responses in flight
    mem_lat = 5; gnt_en = 1'b1;
    exp_adr.push_back(32'h38); exp_adr.push_back(32'h3C); exp_adr.push_back(32'h40);
    step(3); gnt_en = 1'b0; redirect_v_i = 1'b1; redirect_pc_i = 32'h100;
    #2 check("redir_req_kill", 32'(imem_req_o), 0);
    @(negedge clk); redirect_v_i = 1'b0; gnt_en = 1'b1; exp_fetch(32'h100);
    @(negedge clk); gnt_en = 1'b0;
    step(10);

    // Redirect coinciding with a response and a pop (count 3, one in flight)
    mem_lat = 3; ready_i = 1'b0; gnt_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_adr.push_back(32'h104 + 32'(i * 4));
    exp_out.push_back('{instr: mem_word(32'h104), pc: 32'h104, mis: 1'b0});
    step(6); gnt_en = 1'b0; ready_i = 1'b1; redirect_v_i = 1'b1; redirect_pc_i = 32'h200;
    #2 check("coll_rvalid", 32'(imem_rvalid_i), 1);
    @(negedge clk); redirect_v_i = 1'b0; gnt_en = 1'b1; exp_fetch(32'h200);
    #2 check("coll_flush_empty", 32'(valid_o), 0);
    @(negedge clk); gnt_en = 1'b0;
    step(6);

    // Redirect with a full FIFO and a pop in the same cycle
    mem_lat = 1; ready_i = 1'b0; gnt_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_adr.push_back(32'h204 + 32'(i * 4));
    exp_out.push_back('{instr: mem_word(32'h204), pc: 32'h204, mis: 1'b0});
    step(8); gnt_en = 1'b0; ready_i = 1'b1; redirect_v_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    #2 check("full_req_off", 32'(imem_req_o), 0);
    @(negedge clk); redirect_v_i = 1'b0;
    #2 check("full_flush_empty", 32'(valid_o), 0);

    // PC wrap
    @(negedge clk); gnt_en = 1'b1;
    exp_fetch(32'hFFFF_FFF8); exp_fetch(32'hFFFF_FFFC); exp_fetch(32'h0);
    step(3); gnt_en = 1'b0;
    step(5); #2;
    check("wrap_next_adr", imem_adr_o, 32'h4);

    // Misaligned redirect
    @(negedge clk); redirect_v_i = 1'b1; redirect_pc_i = 32'h102;
`ifdef IFETCH_MISALIGN_EXC_EN
    exp_out.push_back('{instr: 32'h0, pc: 32'h102, mis: 1'b1});
    @(negedge clk); redirect_v_i = 1'b0; gnt_en = 1'b1;
    step(4); #2;
    check("halt_no_req", 32'(imem_req_o), 0);
    @(negedge clk); redirect_v_i = 1'b1; redirect_pc_i = 32'h200;
    @(negedge clk); redirect_v_i = 1'b0; exp_fetch(32'h200);
    @(negedge clk); gnt_en = 1'b0;
`else
    @(negedge clk); redirect_v_i = 1'b0; gnt_en = 1'b1; exp_fetch(32'h100);
    @(negedge clk); gnt_en = 1'b0;
`endif
    step(6); #2;
    check("out_queue_drained", 32'(exp_out.size()), 0);
    check("adr_queue_drained", 32'(exp_adr.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the decoder.
- Owns the PC and issues word requests to the instruction memory port.
- Buffers returned words in an in-order FIFO and presents {instr, pc} to decode through a valid/ready handshake.
- Handles pipeline redirects (branch/jump/trap/mret) by flushing buffered words and discarding stale in-flight responses.

Parameters:
- FIFO_DEPTH, 4, number of instruction entries buffered (power of 2, >=2); also the bound on in-flight plus buffered words.
- RESET_VECTOR, 32'h0000_0000, PC loaded at reset.

Ports:
- clk  input  1  core clock
- reset_n  input  1  synchronous active-low reset
- imem_req_o  output  1  fetch request valid
- imem_adr_o  output  XLEN  fetch address; always word aligned
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response valid; responses return in order, >=1 cycle after grant
- imem_rdata_i  input  XLEN  returned instruction word
- redirect_v_i  input  1  redirect from execute/trap logic
- redirect_pc_i  input  XLEN  redirect target
- valid_o  output  1  FIFO head valid toward decoder
- ready_i  input  1  decoder accepts head
- instr_o  output  XLEN  head instruction; feeds decoder instr_i
- pc_o  output  XLEN  head PC
- instr_misalign_o  output  1  head carries fetch-misaligned exception (0 when the optional feature is out)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n; there is no asynchronous reset.
- Reset (reset_n=0 at a clk edge):
  - pc <= RESET_VECTOR; FIFO empty; outstanding=0; drop_cnt=0; state <= BOOT.
  - All outputs 0, except imem_adr_o = pc = RESET_VECTOR.
  - Any response arriving during reset is ignored.
- FSM states:
  - BOOT: no request. Next state is always FETCH. The first request is therefore asserted in the 2nd cycle after reset deasserts.
  - FETCH:
    - imem_req_o = ~redirect_v_i & (fifo_count + outstanding < FIFO_DEPTH).
    - imem_adr_o = pc.
    - On req&gnt: pc <= pc+4 and outstanding++.
    - Held request: address and req stay stable until granted, unless a redirect occurs.
  - HALT: only reachable with the optional feature. No requests. Exits to FETCH only on a redirect to an aligned PC.
- Responses:
  - Each rvalid decrements outstanding.
  - If drop_cnt>0, or redirect_v_i is high this cycle, the response is discarded and drop_cnt decrements when nonzero.
  - Otherwise the response is pushed as {rdata, pc_of_request}. The request PC is tracked in a small PC FIFO (or derived as head-pc arithmetic).
  - The credit rule guarantees the FIFO never overflows; there is no backpressure on responses.
- Output side:
  - valid_o = FIFO non-empty. Head fields are driven straight from storage; there is no bypass, so response-to-valid_o latency is 1 cycle.
  - Pop on valid_o & ready_i.
  - Push and pop in the same cycle is allowed at any occupancy, including full (count unchanged).
- Redirect (redirect_v_i=1):
  - Priority over everything. FIFO flushed next cycle; pc <= {redirect_pc_i[XLEN-1:2],2'b00}; imem_req_o forced 0 this cycle.
  - drop_cnt <= outstanding after this cycle's retirement.
  - A handshake completing in the same cycle still counts as consumed; squashing it is the downstream's job.
  - Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
  - Redirect while a request is held un-granted: the request is abandoned. The memory must not grant when req=0.
- Widths: counters are $clog2(FIFO_DEPTH+1) bits. pc wraps modulo 2^XLEN (0xFFFF_FFFC+4 -> 0).

Optional Feature:
- Macro: IFETCH_MISALIGN_EXC_EN.
- Defined:
  - A redirect with redirect_pc_i[1:0]!=0 issues no request.
  - It pushes one entry {instr=0, pc=redirect_pc_i unmasked, misalign=1} the next cycle, after the flush.
  - State goes to HALT until the next aligned redirect.
  - instr_misalign_o shows the head's flag.
- Undefined:
  - Low PC bits are masked to 00, fetch continues normally.
  - instr_misalign_o is tied 0; HALT is unreachable.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after grant, ready=1 -> first req at cycle 2 with adr 0x0; pc_o sequence 0x0,0x4,0x8…, one instr per cycle sustained.
- ready_i=0 with FIFO_DEPTH=4 -> exactly 4 grants, then imem_req_o=0; valid_o held with head pc 0x0; ready raised -> in-order drain, requests resume.
- 3 requests in flight (responses delayed 5 cycles), redirect to 0x100 -> all 3 stale responses dropped; first valid_o shows pc_o=0x100 with rdata from adr 0x100.
- Redirect in the same cycle as a response and as a pop at full FIFO -> response discarded, FIFO empty next cycle, no overflow or underflow, drop_cnt correct.
- Start from pc 0xFFFF_FFF8 (via redirect) -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- With IFETCH_MISALIGN_EXC_EN, redirect to 0x102 -> one entry pc_o=0x102, instr_misalign_o=1, no further requests; redirect to 0x200 -> fetching resumes. Without the macro, the same redirect fetches from 0x100.
